bmw_level_sram: RTL

- Per-level node storage for the BMW PIFO tree; sits directly downstream of the pop RPU pair and serves its read/write requests.
- Port 0 serves even levels and port 1 serves odd levels.
- One 1R1W memory per tree level, 1-cycle registered read, same-cycle write-to-read bypass.
- Hardware zero-fill after reset, so empty sub-tree counts read as 0 before any push.

---
 rtl/bmw_pifo_pkg.sv | 34 +++
 rtl/bmw_level_sram_if.sv | 34 +++
 rtl/bmw_sram_1r1w.sv | 31 +++
 rtl/bmw_level_sram.sv | 126 ++++++++++++
 4 files changed

// File: rtl/bmw_pifo_pkg.sv
// Shared types and width helpers for the BMW PIFO level storage.
package bmw_pifo_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int node_w(input int ctw, input int mtw, input int ptw);
    return ctw + mtw + ptw;
  endfunction

  function automatic int word_w(input int ctw, input int mtw, input int ptw);
    return 4 * node_w(ctw, mtw, ptw);
  endfunction

  // Node k of a word is {cnt_k, val_k}; val_k carries metadata above the payload.
  function automatic int val_lsb(input int k, input int nw);
    return k * nw;
  endfunction

  function automatic int cnt_lsb(input int k, input int nw, input int ptw, input int mtw);
    return k * nw + ptw + mtw;
  endfunction

  function automatic int level_depth(input int l);
    return 1 << (2 * l);
  endfunction

  function automatic int level_aw(input int l);
    return 2 * l;
  endfunction

endpackage

// File: rtl/bmw_level_sram_if.sv
// Request/response bundle between the pop RPU pair (master) and level storage (slave).
interface bmw_level_sram_if
  import bmw_pifo_pkg::*;
#(
  parameter int WW  = 104,
  parameter int LW  = 3,
  parameter int ADW = 20
);
  // Valid-only requests, no ready: a request high in a cycle is consumed in that
  // cycle when o_init_done is 1 and discarded otherwise; read data lands one edge later.
  logic [1:0]                i_read;
  logic [1:0][LW-1:0]        i_read_level;
  logic [1:0][ADW-1:0]       i_read_addr;
  logic [1:0][WW-1:0]        o_read_data;
  logic [1:0]                i_write;
  logic [1:0][LW-1:0]        i_write_level;
  logic [1:0][ADW-1:0]       i_write_addr;
  logic [1:0][WW-1:0]        i_write_data;
  logic                      o_init_done;
  logic                      o_err;
  state_t                    dbg_state;

  modport master (
    output i_read, i_read_level, i_read_addr,
    output i_write, i_write_level, i_write_addr, i_write_data,
    input  o_read_data, o_init_done, o_err, dbg_state
  );

  modport slave (
    input  i_read, i_read_level, i_read_addr,
    input  i_write, i_write_level, i_write_addr, i_write_data,
    output o_read_data, o_init_done, o_err, dbg_state
  );
endinterface

// File: rtl/bmw_sram_1r1w.sv
// 1R1W word memory: registered read that holds when idle, same-address write bypass.
module bmw_sram_1r1w #(
  parameter  int DEPTH = 4,
  parameter  int WW    = 104,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [WW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WW-1:0] wr_data
);

  logic [WW-1:0] mem [DEPTH];
  logic          bypass;

  assign bypass = wr_en && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)    rd_data <= '0;
    else if (rd_en) rd_data <= bypass ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/bmw_level_sram.sv
// Per-level node storage for the BMW PIFO tree: zero-fill after reset, then
// port 0 serves even levels and port 1 serves odd levels.
module bmw_level_sram
  import bmw_pifo_pkg::*;
#(
  parameter  int PTW   = 16,
  parameter  int MTW   = 0,
  parameter  int CTW   = 10,
  parameter  int ADW   = 20,
  parameter  int LEVEL = 8,
  localparam int NW    = node_w(CTW, MTW, PTW),
  localparam int WW    = 4 * NW,
  localparam int LW    = $clog2(LEVEL)
) (
  input logic              i_clk,
  input logic              i_arst_n,
  bmw_level_sram_if.slave  bus
);

  localparam int FAW = 2 * (LEVEL - 1);
  localparam logic [FAW-1:0] FILL_LAST = {FAW{1'b1}};

  state_t                state_q, state_d;
  logic [FAW-1:0]        fill_q, fill_d;
  logic                  err_q, err_d;
  logic [1:0][LW-1:0]    sel_q, sel_d;
  logic [1:0]            rd_ok, wr_ok;
  logic [WW-1:0]         lvl_rd [LEVEL];

  function automatic logic level_ok(input logic [LW-1:0] lvl, input logic port);
    return (lvl[0] == port) && (int'(lvl) < LEVEL);
  endfunction

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q  <= ST_INIT;
      fill_q   <= '0;
      err_q    <= 1'b0;
      sel_q[0] <= LW'(0);
      sel_q[1] <= LW'(1);
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

  // Requests are only qualified in ST_RUN; violations are dropped and flagged.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    err_d   = err_q;
    sel_d   = sel_q;
    rd_ok   = '0;
    wr_ok   = '0;
    if (state_q == ST_INIT) begin
      fill_d = fill_q + FAW'(1);
      if (fill_q == FILL_LAST) state_d = ST_RUN;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (bus.i_read[p]) begin
          if (level_ok(bus.i_read_level[p], 1'(p))) begin
            rd_ok[p] = 1'b1;
            sel_d[p] = bus.i_read_level[p];
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.i_write[p]) begin
          if (level_ok(bus.i_write_level[p], 1'(p))) wr_ok[p] = 1'b1;
          else                                       err_d    = 1'b1;
        end
      end
    end
  end

  for (genvar l = 0; l < LEVEL; l++) begin : g_lvl
    localparam int DEPTH = level_depth(l);
    localparam int AW    = (DEPTH > 1) ? level_aw(l) : 1;
    localparam int P     = l % 2;

    logic          rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [WW-1:0] wr_data;

    // The fill sweep owns the write port until every level has been cleared.
    always_comb begin
      rd_en   = rd_ok[P] && (int'(bus.i_read_level[P]) == l);
      rd_addr = (l == 0) ? '0 : bus.i_read_addr[P][AW-1:0];
      if (state_q == ST_INIT) begin
        wr_en   = int'(fill_q) < DEPTH;
        wr_addr = fill_q[AW-1:0];
        wr_data = '0;
      end else begin
        wr_en   = wr_ok[P] && (int'(bus.i_write_level[P]) == l);
        wr_addr = (l == 0) ? '0 : bus.i_write_addr[P][AW-1:0];
        wr_data = bus.i_write_data[P];
      end
    end

    bmw_sram_1r1w #(
      .DEPTH (DEPTH),
      .WW    (WW)
    ) u_mem (
      .clk     (i_clk),
      .arst_n  (i_arst_n),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (lvl_rd[l]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
    );
  end

  // Each port shows the level it last read; that level's register only moves on its own reads.
  always_comb begin
    for (int p = 0; p < 2; p++) bus.o_read_data[p] = lvl_rd[sel_q[p]];
  end

  assign bus.o_init_done = (state_q == ST_RUN);
  assign bus.o_err       = err_q;
  assign bus.dbg_state   = state_q;

endmodule
